basic_control_unit: RTL and testbench

//  Timing/control sequencer that drives the control inputs of the basic-computer datapath.
//  It consumes the datapath status (IR, AC, DR, E, FGI, FGO, IEN) and issues per-cycle

---
 rtl/basic_control_unit.sv | 207 ++++++++++++++++++++
 tb/tb_basic_control_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/basic_control_unit.sv
// Timing/control sequencer for the basic-computer datapath.
// Holds SC, I, D, R and S; every control strobe is a combinational decode
// of that state plus the datapath status inputs.
// run is a one-cycle pulse that is sampled only while the sequencer is
// stopped (S=0); while running it is ignored.
module basic_control_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] IR_OUT,
    input  logic [15:0] AC_OUT,
    input  logic [15:0] DR_OUT,
    input  logic        OUT_E,
    input  logic        OUT_FGI,
    input  logic        OUT_FGO,
    input  logic        OUT_INE,
    output logic        LD_AR,
    output logic        LD_PC,
    output logic        LD_DR,
    output logic        LD_IR,
    output logic        LD_TR,
    output logic        LD_OUTR,
    output logic        LD_AC,
    output logic        INC_AR,
    output logic        INC_PC,
    output logic        INC_DR,
    output logic        INC_TR,
    output logic        INC_AC,
    output logic        CLR_AR,
    output logic        CLR_PC,
    output logic        CLR_DR,
    output logic        CLR_TR,
    output logic        CLR_AC,
    output logic        Read_memory,
    output logic        Write_memory,
    output logic [2:0]  Sel,
    output logic [3:0]  aluop,
    output logic        Write_E,
    output logic        SET_INE,
    output logic        reset_INE,
    output logic        reset_FGI,
    output logic        reset_FGO,
    output logic        halted,
    output logic [2:0]  sc_out
);

    localparam logic [3:0] ALU_AND = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_LDA = 4'd3;
    localparam logic [3:0] ALU_CMA = 4'd4;
    localparam logic [3:0] ALU_CIR = 4'd5;
    localparam logic [3:0] ALU_CIL = 4'd6;
    localparam logic [3:0] ALU_CLE = 4'd7;
    localparam logic [3:0] ALU_CME = 4'd8;
    localparam logic [3:0] ALU_INP = 4'd9;

    logic [2:0] sc_q, sc_d;
    logic [2:0] d_q, d_d;
    logic       i_q, i_d;
    logic       r_q, r_d;
    logic       s_q, s_d;
    logic       sc_clr;
    logic       hlt;
    logic       ac_clr, ac_ld;

    assign halted = ~s_q;
    assign sc_out = sc_q;

    // CLR beats LD beats INC when a register-reference word hits AC more than once.
    assign ac_clr = IR_OUT[11];
    assign ac_ld  = IR_OUT[9] | IR_OUT[7] | IR_OUT[6];

    // Decode the current timing step into datapath strobes; silent in reset or halt.
    always_comb begin
        LD_AR = 1'b0; LD_PC = 1'b0; LD_DR = 1'b0; LD_IR = 1'b0;
        LD_TR = 1'b0; LD_OUTR = 1'b0; LD_AC = 1'b0;
        INC_AR = 1'b0; INC_PC = 1'b0; INC_DR = 1'b0; INC_TR = 1'b0; INC_AC = 1'b0;
        CLR_AR = 1'b0; CLR_PC = 1'b0; CLR_DR = 1'b0; CLR_TR = 1'b0; CLR_AC = 1'b0;
        Read_memory = 1'b0; Write_memory = 1'b0;
        Sel = 3'd0; aluop = 4'd0; Write_E = 1'b0;
        SET_INE = 1'b0; reset_INE = 1'b0; reset_FGI = 1'b0; reset_FGO = 1'b0;
        sc_clr = 1'b0;
        hlt = 1'b0;
        if (!reset && s_q) begin
            if (r_q && sc_q <= 3'd2) begin
                // Interrupt cycle: save PC at M[0], vector to PC=1.
                case (sc_q)
                    3'd0:    begin CLR_AR = 1'b1; Sel = 3'd2; LD_TR = 1'b1; end
                    3'd1:    begin Sel = 3'd6; Write_memory = 1'b1; CLR_PC = 1'b1; end
                    default: begin INC_PC = 1'b1; reset_INE = 1'b1; sc_clr = 1'b1; end
                endcase
            end else if (sc_q <= 3'd2) begin
                case (sc_q)
                    3'd0:    begin Sel = 3'd2; LD_AR = 1'b1; end
                    3'd1:    begin Sel = 3'd7; Read_memory = 1'b1; LD_IR = 1'b1; INC_PC = 1'b1; end
                    default: begin Sel = 3'd5; LD_AR = 1'b1; end
                endcase
            end else if (d_q == 3'd7) begin
                sc_clr = 1'b1;
                if (!i_q) begin
                    // Register reference: several bits may act in one cycle.
                    CLR_AC  = ac_clr;
                    LD_AC   = ac_ld & ~ac_clr;
                    INC_AC  = IR_OUT[5] & ~ac_clr & ~ac_ld;
                    Write_E = IR_OUT[10] | IR_OUT[8] | IR_OUT[7] | IR_OUT[6];
                    if (IR_OUT[10])     aluop = ALU_CLE;
                    else if (IR_OUT[9]) aluop = ALU_CMA;
                    else if (IR_OUT[8]) aluop = ALU_CME;
                    else if (IR_OUT[7]) aluop = ALU_CIR;
                    else if (IR_OUT[6]) aluop = ALU_CIL;
                    INC_PC = (IR_OUT[4] & ~AC_OUT[15]) | (IR_OUT[3] & AC_OUT[15]) |
                             (IR_OUT[2] & (AC_OUT == 16'd0)) | (IR_OUT[1] & ~OUT_E);
                    hlt = IR_OUT[0];
                end else begin
                    // Input/output instructions.
                    if (IR_OUT[11]) begin aluop = ALU_INP; LD_AC = 1'b1; reset_FGI = 1'b1; end
                    if (IR_OUT[10]) begin Sel = 3'd4; LD_OUTR = 1'b1; reset_FGO = 1'b1; end
                    INC_PC    = (IR_OUT[9] & OUT_FGI) | (IR_OUT[8] & OUT_FGO);
                    SET_INE   = IR_OUT[7];
                    reset_INE = IR_OUT[6];
                end
            end else if (sc_q == 3'd3) begin
                // Indirect address fetch; direct addressing idles here.
                if (i_q) begin Sel = 3'd7; Read_memory = 1'b1; LD_AR = 1'b1; end
            end else begin
                case (d_q)
                    3'd0, 3'd1, 3'd2: begin
                        if (sc_q == 3'd4) begin
                            Sel = 3'd7; Read_memory = 1'b1; LD_DR = 1'b1;
                        end else begin
                            aluop   = (d_q == 3'd0) ? ALU_AND : (d_q == 3'd1) ? ALU_ADD : ALU_LDA;
                            LD_AC   = 1'b1;
                            Write_E = (d_q == 3'd1);
                            sc_clr  = 1'b1;
                        end
                    end
                    3'd3: begin Sel = 3'd4; Write_memory = 1'b1; sc_clr = 1'b1; end
                    3'd4: begin Sel = 3'd1; LD_PC = 1'b1; sc_clr = 1'b1; end
                    3'd5: begin
                        if (sc_q == 3'd4) begin
                            Sel = 3'd2; Write_memory = 1'b1; INC_AR = 1'b1;
                        end else begin
                            Sel = 3'd1; LD_PC = 1'b1; sc_clr = 1'b1;
                        end
                    end
                    3'd6: begin
                        case (sc_q)
                            3'd4:    begin Sel = 3'd7; Read_memory = 1'b1; LD_DR = 1'b1; end
                            3'd5:    INC_DR = 1'b1;
                            default: begin
                                Sel = 3'd3; Write_memory = 1'b1;
                                INC_PC = (DR_OUT == 16'd0);
                                sc_clr = 1'b1;
                            end
                        endcase
                    end
                    default: sc_clr = 1'b1;
                endcase
            end
        end
    end

    // Next-state for SC, I, D, R and S; a stopped sequencer only watches run.
    always_comb begin
        sc_d = sc_q;
        d_d  = d_q;
        i_d  = i_q;
        r_d  = r_q;
        s_d  = s_q;
        if (!s_q) begin
            if (run) begin
                s_d  = 1'b1;
                sc_d = 3'd0;
            end
        end else begin
            sc_d = sc_clr ? 3'd0 : sc_q + 3'd1;
            if (!r_q && sc_q == 3'd2) begin
                d_d = IR_OUT[14:12];
                i_d = IR_OUT[15];
            end
            if (r_q && sc_q == 3'd2)
                r_d = 1'b0;
            else if (!r_q && sc_q >= 3'd3 && OUT_INE && (OUT_FGI || OUT_FGO))
                r_d = 1'b1;
            if (hlt)
                s_d = 1'b0;
        end
    end

    // Sequencer state registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sc_q <= 3'd0;
            d_q  <= 3'd0;
            i_q  <= 1'b0;
            r_q  <= 1'b0;
            s_q  <= 1'b1;
        end else begin
            sc_q <= sc_d;
            d_q  <= d_d;
            i_q  <= i_d;
            r_q  <= r_d;
            s_q  <= s_d;
        end
    end

endmodule

// File: tb/tb_basic_control_unit.sv
// Bench for basic_control_unit: all outputs are packed into one word
// {sc_out, halted, aluop, Sel, flag strobes, memory strobes, CLR, INC, LD}
// and compared cycle by cycle against words queued by the stimulus.
module tb_basic_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [15:0] IR_OUT = 16'd0, AC_OUT = 16'd0, DR_OUT = 16'd0;
    logic        OUT_E = 1'b0, OUT_FGI = 1'b0, OUT_FGO = 1'b0, OUT_INE = 1'b0;
    logic LD_AR, LD_PC, LD_DR, LD_IR, LD_TR, LD_OUTR, LD_AC;
    logic INC_AR, INC_PC, INC_DR, INC_TR, INC_AC;
    logic CLR_AR, CLR_PC, CLR_DR, CLR_TR, CLR_AC;
    logic Read_memory, Write_memory, Write_E;
    logic SET_INE, reset_INE, reset_FGI, reset_FGO, halted;
    logic [2:0] Sel, sc_out;
    logic [3:0] aluop;

    basic_control_unit dut (
        .clock(clock), .reset(reset), .run(run),
        .IR_OUT(IR_OUT), .AC_OUT(AC_OUT), .DR_OUT(DR_OUT),
        .OUT_E(OUT_E), .OUT_FGI(OUT_FGI), .OUT_FGO(OUT_FGO), .OUT_INE(OUT_INE),
        .LD_AR(LD_AR), .LD_PC(LD_PC), .LD_DR(LD_DR), .LD_IR(LD_IR),
        .LD_TR(LD_TR), .LD_OUTR(LD_OUTR), .LD_AC(LD_AC),
        .INC_AR(INC_AR), .INC_PC(INC_PC), .INC_DR(INC_DR), .INC_TR(INC_TR), .INC_AC(INC_AC),
        .CLR_AR(CLR_AR), .CLR_PC(CLR_PC), .CLR_DR(CLR_DR), .CLR_TR(CLR_TR), .CLR_AC(CLR_AC),
        .Read_memory(Read_memory), .Write_memory(Write_memory),
        .Sel(Sel), .aluop(aluop), .Write_E(Write_E),
        .SET_INE(SET_INE), .reset_INE(reset_INE), .reset_FGI(reset_FGI), .reset_FGO(reset_FGO),
        .halted(halted), .sc_out(sc_out)
    );

    // Clock and watchdog.
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded, summary not reached", $time);
        $fatal(1, "watchdog expired");
    end

    logic [34:0] dut_word;
    assign dut_word = {sc_out, halted, aluop, Sel, reset_FGO, reset_FGI, reset_INE, SET_INE,
                       Write_E, Write_memory, Read_memory,
                       CLR_AC, CLR_TR, CLR_DR, CLR_PC, CLR_AR,
                       INC_AC, INC_TR, INC_DR, INC_PC, INC_AR,
                       LD_AC, LD_OUTR, LD_TR, LD_IR, LD_DR, LD_PC, LD_AR};

    localparam logic [34:0] M_LD_AR   = 35'd1 << 0;
    localparam logic [34:0] M_LD_PC   = 35'd1 << 1;
    localparam logic [34:0] M_LD_DR   = 35'd1 << 2;
    localparam logic [34:0] M_LD_IR   = 35'd1 << 3;
    localparam logic [34:0] M_LD_TR   = 35'd1 << 4;
    localparam logic [34:0] M_LD_OUTR = 35'd1 << 5;
    localparam logic [34:0] M_LD_AC   = 35'd1 << 6;
    localparam logic [34:0] M_INC_AR  = 35'd1 << 7;
    localparam logic [34:0] M_INC_PC  = 35'd1 << 8;
    localparam logic [34:0] M_INC_DR  = 35'd1 << 9;
    localparam logic [34:0] M_INC_AC  = 35'd1 << 11;
    localparam logic [34:0] M_CLR_AR  = 35'd1 << 12;
    localparam logic [34:0] M_CLR_PC  = 35'd1 << 13;
    localparam logic [34:0] M_CLR_AC  = 35'd1 << 16;
    localparam logic [34:0] M_RD      = 35'd1 << 17;
    localparam logic [34:0] M_WR      = 35'd1 << 18;
    localparam logic [34:0] M_WE      = 35'd1 << 19;
    localparam logic [34:0] M_SET_INE = 35'd1 << 20;
    localparam logic [34:0] M_RST_INE = 35'd1 << 21;
    localparam logic [34:0] M_RST_FGI = 35'd1 << 22;
    localparam logic [34:0] M_RST_FGO = 35'd1 << 23;
    localparam logic [34:0] M_HALTED  = 35'd1 << 31;

    function automatic logic [34:0] f_sc(input logic [2:0] n);
        f_sc = {n, 32'd0};
    endfunction
    function automatic logic [34:0] f_sel(input logic [2:0] n);
        f_sel = {8'd0, n, 24'd0};
    endfunction
    function automatic logic [34:0] f_alu(input logic [3:0] n);
        f_alu = {4'd0, n, 27'd0};
    endfunction

    // Scoreboard.
    logic [34:0] exp_q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: dut=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_now(input string name);
        logic [34:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: dut=%h want=<empty queue>", name, dut_word);
        end else begin
            e = exp_q.pop_front();
            chk(name, dut_word, e);
        end
    endtask

    // Called at a falling edge: compare just after it, then move to the next falling edge.
    task automatic cycle(input string name);
        #1;
        check_now(name);
        @(negedge clock);
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) cycle(name);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        exp_q.push_back(35'd0);
        #1;
        check_now("reset_state");
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [34:0] w_t0, w_t1, w_t2, w_rd;

    task automatic push_fetch();
        exp_q.push_back(w_t0);
        exp_q.push_back(w_t1);
        exp_q.push_back(w_t2);
    endtask

    // Register-reference and I/O vectors, checked at T3 and at the following T0.
    typedef struct {
        logic [15:0] ir;
        logic [15:0] ac;
        logic        e;
        logic        fgi;
        logic        fgo;
        logic [34:0] exp;
    } vec_t;
    vec_t vecs [26];

    task automatic add_vec(input int k, input logic [15:0] ir, input logic [15:0] ac,
                           input logic e, input logic fgi, input logic fgo, input logic [34:0] exp);
        vecs[k].ir = ir; vecs[k].ac = ac; vecs[k].e = e;
        vecs[k].fgi = fgi; vecs[k].fgo = fgo; vecs[k].exp = exp;
    endtask

    task automatic start_instr(input logic [15:0] ir, input logic [15:0] dr);
        IR_OUT = ir; DR_OUT = dr; AC_OUT = 16'd5;
        OUT_E = 1'b0; OUT_FGI = 1'b0; OUT_FGO = 1'b0; OUT_INE = 1'b0;
        apply_reset();
        push_fetch();
    endtask

    initial begin
        w_t0 = f_sc(3'd0) | f_sel(3'd2) | M_LD_AR;
        w_t1 = f_sc(3'd1) | f_sel(3'd7) | M_RD | M_LD_IR | M_INC_PC;
        w_t2 = f_sc(3'd2) | f_sel(3'd5) | M_LD_AR;
        w_rd = f_sel(3'd7) | M_RD | M_LD_DR;

        add_vec(0,  16'h7800, 16'h0001, 1'b0, 1'b0, 1'b0, M_CLR_AC);
        add_vec(1,  16'h7400, 16'h0001, 1'b0, 1'b0, 1'b0, f_alu(4'd7) | M_WE);
        add_vec(2,  16'h7200, 16'h0001, 1'b0, 1'b0, 1'b0, f_alu(4'd4) | M_LD_AC);
        add_vec(3,  16'h7100, 16'h0001, 1'b0, 1'b0, 1'b0, f_alu(4'd8) | M_WE);
        add_vec(4,  16'h7080, 16'h0001, 1'b0, 1'b0, 1'b0, f_alu(4'd5) | M_LD_AC | M_WE);
        add_vec(5,  16'h7040, 16'h0001, 1'b0, 1'b0, 1'b0, f_alu(4'd6) | M_LD_AC | M_WE);
        add_vec(6,  16'h7020, 16'h0001, 1'b0, 1'b0, 1'b0, M_INC_AC);
        add_vec(7,  16'h7010, 16'h0001, 1'b0, 1'b0, 1'b0, M_INC_PC);
        add_vec(8,  16'h7010, 16'h8000, 1'b0, 1'b0, 1'b0, 35'd0);
        add_vec(9,  16'h7008, 16'h8000, 1'b0, 1'b0, 1'b0, M_INC_PC);
        add_vec(10, 16'h7008, 16'h7FFF, 1'b0, 1'b0, 1'b0, 35'd0);
        add_vec(11, 16'h7004, 16'h0000, 1'b0, 1'b0, 1'b0, M_INC_PC);
        add_vec(12, 16'h7004, 16'h0100, 1'b0, 1'b0, 1'b0, 35'd0);
        add_vec(13, 16'h7002, 16'h0001, 1'b0, 1'b0, 1'b0, M_INC_PC);
        add_vec(14, 16'h7002, 16'h0001, 1'b1, 1'b0, 1'b0, 35'd0);
        add_vec(15, 16'h7820, 16'h0001, 1'b0, 1'b0, 1'b0, M_CLR_AC);
        add_vec(16, 16'h7220, 16'h0001, 1'b0, 1'b0, 1'b0, f_alu(4'd4) | M_LD_AC);
        add_vec(17, 16'h7000, 16'h0001, 1'b0, 1'b0, 1'b0, 35'd0);
        add_vec(18, 16'hF800, 16'h0001, 1'b0, 1'b1, 1'b0, f_alu(4'd9) | M_LD_AC | M_RST_FGI);
        add_vec(19, 16'hF400, 16'h0001, 1'b0, 1'b0, 1'b1, f_sel(3'd4) | M_LD_OUTR | M_RST_FGO);
        add_vec(20, 16'hF200, 16'h0001, 1'b0, 1'b1, 1'b0, M_INC_PC);
        add_vec(21, 16'hF200, 16'h0001, 1'b0, 1'b0, 1'b1, 35'd0);
        add_vec(22, 16'hF100, 16'h0001, 1'b0, 1'b0, 1'b1, M_INC_PC);
        add_vec(23, 16'hF080, 16'h0001, 1'b0, 1'b0, 1'b0, M_SET_INE);
        add_vec(24, 16'hF040, 16'h0001, 1'b0, 1'b0, 1'b0, M_RST_INE);
        add_vec(25, 16'hF000, 16'h0001, 1'b0, 1'b1, 1'b1, 35'd0);

        for (int k = 0; k < 26; k++) begin
            IR_OUT = vecs[k].ir; AC_OUT = vecs[k].ac; OUT_E = vecs[k].e;
            OUT_FGI = vecs[k].fgi; OUT_FGO = vecs[k].fgo; OUT_INE = 1'b0;
            DR_OUT = 16'($urandom_range(0, 65535));
            apply_reset();
            push_fetch();
            exp_q.push_back(f_sc(3'd3) | vecs[k].exp);
            exp_q.push_back(w_t0);
            drain($sformatf("vec%0d_ir%h", k, vecs[k].ir));
        end

        // LDA 0x2005: direct, read at T4, load AC at T5, back to T0.
        start_instr(16'h2005, 16'h1234);
        exp_q.push_back(f_sc(3'd3));
        exp_q.push_back(f_sc(3'd4) | w_rd);
        exp_q.push_back(f_sc(3'd5) | f_alu(4'd3) | M_LD_AC);
        exp_q.push_back(w_t0);
        drain("lda");

        // ADD indirect 0x9010.
        start_instr(16'h9010, 16'h0003);
        exp_q.push_back(f_sc(3'd3) | f_sel(3'd7) | M_RD | M_LD_AR);
        exp_q.push_back(f_sc(3'd4) | w_rd);
        exp_q.push_back(f_sc(3'd5) | f_alu(4'd2) | M_LD_AC | M_WE);
        exp_q.push_back(w_t0);
        drain("add_ind");

        // AND 0x0007.
        start_instr(16'h0007, 16'h00F0);
        exp_q.push_back(f_sc(3'd3));
        exp_q.push_back(f_sc(3'd4) | w_rd);
        exp_q.push_back(f_sc(3'd5) | f_alu(4'd1) | M_LD_AC);
        exp_q.push_back(w_t0);
        drain("and");

        // STA 0x3007.
        start_instr(16'h3007, 16'h0000);
        exp_q.push_back(f_sc(3'd3));
        exp_q.push_back(f_sc(3'd4) | f_sel(3'd4) | M_WR);
        exp_q.push_back(w_t0);
        drain("sta");

        // BUN indirect 0xC007.
        start_instr(16'hC007, 16'h0000);
        exp_q.push_back(f_sc(3'd3) | f_sel(3'd7) | M_RD | M_LD_AR);
        exp_q.push_back(f_sc(3'd4) | f_sel(3'd1) | M_LD_PC);
        exp_q.push_back(w_t0);
        drain("bun_ind");

        // BSA 0x5007.
        start_instr(16'h5007, 16'h0000);
        exp_q.push_back(f_sc(3'd3));
        exp_q.push_back(f_sc(3'd4) | f_sel(3'd2) | M_WR | M_INC_AR);
        exp_q.push_back(f_sc(3'd5) | f_sel(3'd1) | M_LD_PC);
        exp_q.push_back(w_t0);
        drain("bsa");

        // ISZ: incremented DR of zero skips, nonzero does not.
        start_instr(16'h6020, 16'h0000);
        exp_q.push_back(f_sc(3'd3));
        exp_q.push_back(f_sc(3'd4) | w_rd);
        exp_q.push_back(f_sc(3'd5) | M_INC_DR);
        exp_q.push_back(f_sc(3'd6) | f_sel(3'd3) | M_WR | M_INC_PC);
        exp_q.push_back(w_t0);
        drain("isz_zero");
        start_instr(16'h6020, 16'h0002);
        exp_q.push_back(f_sc(3'd3));
        exp_q.push_back(f_sc(3'd4) | w_rd);
        exp_q.push_back(f_sc(3'd5) | M_INC_DR);
        exp_q.push_back(f_sc(3'd6) | f_sel(3'd3) | M_WR);
        exp_q.push_back(w_t0);
        drain("isz_nonzero");

        // Interrupt: FGI rises during T4 of LDA; the instruction finishes, then RT0..RT2.
        start_instr(16'h2005, 16'h1234);
        OUT_INE = 1'b1;
        exp_q.push_back(f_sc(3'd3));
        drain("irq_lda_head");
        OUT_FGI = 1'b1;
        exp_q.push_back(f_sc(3'd4) | w_rd);
        exp_q.push_back(f_sc(3'd5) | f_alu(4'd3) | M_LD_AC);
        exp_q.push_back(f_sc(3'd0) | M_CLR_AR | f_sel(3'd2) | M_LD_TR);
        exp_q.push_back(f_sc(3'd1) | f_sel(3'd6) | M_WR | M_CLR_PC);
        exp_q.push_back(f_sc(3'd2) | M_INC_PC | M_RST_INE);
        drain("irq_cycle");
        OUT_INE = 1'b0;
        OUT_FGI = 1'b0;
        exp_q.push_back(w_t0);
        drain("irq_return");

        // Interrupt pending from the start: not taken during T0..T2, taken after T3.
        start_instr(16'h7020, 16'h0000);
        OUT_INE = 1'b1;
        OUT_FGO = 1'b1;
        exp_q.push_back(f_sc(3'd3) | M_INC_AC);
        exp_q.push_back(f_sc(3'd0) | M_CLR_AR | f_sel(3'd2) | M_LD_TR);
        exp_q.push_back(f_sc(3'd1) | f_sel(3'd6) | M_WR | M_CLR_PC);
        exp_q.push_back(f_sc(3'd2) | M_INC_PC | M_RST_INE);
        exp_q.push_back(w_t0);
        drain("irq_pending");
        OUT_INE = 1'b0;
        OUT_FGO = 1'b0;

        // HLT, 20 silent cycles, then run restarts at T0; run while running is ignored.
        start_instr(16'h7001, 16'h0000);
        exp_q.push_back(f_sc(3'd3));
        for (int n = 0; n < 20; n++) exp_q.push_back(M_HALTED);
        drain("hlt");
        run = 1'b1;
        IR_OUT = 16'h7020;
        exp_q.push_back(M_HALTED);
        cycle("hlt_run_pulse");
        run = 1'b0;
        exp_q.push_back(w_t0);
        cycle("run_restart_t0");
        run = 1'b1;
        exp_q.push_back(w_t1);
        cycle("run_ignored_t1");
        run = 1'b0;
        exp_q.push_back(w_t2);
        exp_q.push_back(f_sc(3'd3) | M_INC_AC);
        exp_q.push_back(w_t0);
        drain("after_restart");

        // Asynchronous reset in the middle of BSA T4.
        start_instr(16'h5007, 16'h0000);
        exp_q.push_back(f_sc(3'd3));
        drain("bsa_head");
        exp_q.push_back(f_sc(3'd4) | f_sel(3'd2) | M_WR | M_INC_AR);
        #1;
        check_now("bsa_t4");
        #1;
        reset = 1'b1;
        exp_q.push_back(35'd0);
        #1;
        check_now("bsa_async_reset");
        @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(w_t0);
        drain("post_reset_t0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
